fb_write_scheduler: RTL and testbench
=====================================

// Module: fb_write_scheduler
// PURPOSE
//   Owns the VGA framebuffer's single write port and shares it between two pixel requesters
//   and a built-in screen-clear sweep. Sits between the animators and VGA_framebuffer, and
//   replaces ad-hoc muxing of x/y/pixel_color in the top level.
//   Screen clear runs at power-up and on request. Requests are then arbitrated one pixel per
//   cycle with a valid/grant handshake, and every write address is bounds-checked.
// PARAMETERS
//   SCREEN_W  640  visible width;  legal x is 0..SCREEN_W-1
//   SCREEN_H  480  visible height; legal y is 0..SCREEN_H-1
//   CW        11   coordinate width; matches the framebuffer x/y ports
// PORTS
//   CLOCK_50     in   1   system clock
//   reset        in   1   synchronous, active-high; already metastability-filtered
//   clear_req    in   1   level; start (or restart) a full-screen clear
//   req_i[1:0]   in   2   requester i has a pixel pending
//   x_i[1:0]     in   2xCW  requester pixel x
//   y_i[1:0]     in   2xCW  requester pixel y
//   color_i[1:0] in   2   requester pixel colour (1 = white)
//   gnt_o[1:0]   out  2   one-hot; pixel i accepted in this cycle
//   fb_x         out  CW  framebuffer write x
//   fb_y         out  CW  framebuffer write y
//   fb_color     out  1   framebuffer write colour
//   fb_write     out  1   framebuffer write enable
//   clear_busy   out  1   sweep in progress
//   oob_err      out  1   sticky; an out-of-range request was dropped
// BEHAVIOUR
//   Reset: all outputs 0. Internal state is S_CLEAR with the sweep at (0,0), so clearing
//     starts on the first cycle after reset deasserts.
//   States:
//     S_CLEAR -> S_SERVE after pixel (SCREEN_W-1, SCREEN_H-1) is issued.
//     S_SERVE -> S_CLEAR when clear_req=1; sweep reloads to (0,0).
//   S_CLEAR
//     - Writes one pixel per cycle: fb_write=1, fb_color=0.
//     - Scan order is x fastest; x wraps to 0 after SCREEN_W-1 and y increments.
//     - One sweep is 307200 cycles. clear_busy=1 throughout.
//     - gnt_o=0; requests wait, and requesters must hold req/x/y/color until granted.
//     - clear_req during S_CLEAR restarts the sweep at (0,0) next cycle.
//   S_SERVE
//     - gnt_o is combinational from req_i in the same cycle. At most one bit is set.
//     - Winner's x/y/color is registered onto fb_* with fb_write=1 one cycle later
//       (latency 1). No request pending -> fb_write=0 next cycle; fb_x/fb_y/fb_color hold.
//     - Out-of-range request (x>=SCREEN_W or y>=SCREEN_H) is still granted (consumed), but
//       fb_write=0 and oob_err sets. oob_err clears only on reset.
//     - fb_write never carries an out-of-range address in either state.
//     - Simultaneous clear_req and req: no grant that cycle; the clear wins.
//   Arithmetic: coordinates are unsigned CW bits; comparisons are unsigned.
// CONFIGURATION
//   FB_SCHED_ROUND_ROBIN_EN
//     - Defined: on a tie, the requester not granted most recently wins. The last-grant
//       pointer resets to 1, so requester 0 wins the first tie.
//     - Undefined: fixed priority; requester 0 always wins ties and requester 1 can starve.
// STRUCTURE
//   Package fb_pkg holds:
//     - SCREEN_W, SCREEN_H, CW
//     - typedef logic [CW-1:0] coord_t
//     - typedef struct packed {coord_t x; coord_t y; logic color;} pixel_t
//     - typedef enum logic {S_CLEAR, S_SERVE} sched_state_t
//   Sub-module fb_clear_sweeper is the raster x/y counter.
//     - Ports: clk, restart, advance, x, y, last.
//     - Instantiated once.
// TESTING
//   1 Reset pulse, no requests: fb_write=1, fb_color=0, fb_x/fb_y go (0,0),(1,0) ...
//     (639,0),(0,1) ... (639,479). clear_busy falls 307200 cycles after reset deasserts.
//   2 S_SERVE, req_i=01 with (10,20,1): gnt_o=01 same cycle. Next cycle fb_x=10, fb_y=20,
//     fb_color=1, fb_write=1. Drop req: fb_write=0 the following cycle.
//   3 Both requesting continuously, (5,5) and (6,6):
//     - fixed priority: gnt_o=01 every cycle.
//     - FB_SCHED_ROUND_ROBIN_EN defined: gnt_o alternates 01,10,01, fb_x alternates 5,6.
//   4 req_i=10 with (640,0): gnt_o=10, fb_write stays 0, oob_err=1. Then (639,479) is
//     written normally and oob_err remains 1.
//   5 clear_req pulse while req_i=01 is held: no grant during the 307200-cycle sweep. The
//     pending pixel is granted on the first S_SERVE cycle.
//   6 clear_req mid-sweep at (100,3): next fb_x/fb_y=(0,0). Reset mid-sweep: all outputs
//     0, then the sweep restarts at (0,0).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and screen geometry for the framebuffer write scheduler.
//   SCREEN_W / SCREEN_H : visible raster size (legal x 0..SCREEN_W-1, y 0..SCREEN_H-1)
//   CW                  : coordinate width, matches the VGA_framebuffer x/y ports
//   coord_t, pixel_t    : one coordinate / one pixel write (x, y, colour)
//   sched_state_t       : scheduler state (sweep clearing vs. serving requesters)
package fb_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned CW       = 11;

    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   color;
    } pixel_t;

    typedef enum logic {S_CLEAR, S_SERVE} sched_state_t;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Requester-side pixel bus of the framebuffer write scheduler.
//   req[1:0]   requester i has a pixel pending (held until granted)
//   x[1:0]     requester pixel x
//   y[1:0]     requester pixel y
//   color[1:0] requester pixel colour (1 = white)
//   gnt[1:0]   one-hot, combinational; pixel i is consumed this cycle
// Modports: master = the animators (drive requests), slave = the scheduler.
interface fb_write_scheduler_if;
    import fb_pkg::*;

    logic   [1:0] req;
    coord_t [1:0] x;
    coord_t [1:0] y;
    logic   [1:0] color;
    logic   [1:0] gnt;

    modport master (output req, output x, output y, output color, input gnt);
    modport slave  (input req, input x, input y, input color, output gnt);

endinterface

// File: rtl/fb_clear_sweeper.sv
// Raster x/y counter for the screen-clear sweep (x fastest, then y).
//   clk     : system clock
//   restart : present (0,0) this cycle and reload the sweep from there
//   advance : the presented coordinate is consumed; step to the next one
//   x, y    : coordinate to write this cycle
//   last    : x, y is the final pixel (SCREEN_W-1, SCREEN_H-1)
// The counter has no reset of its own; holding restart high does the job.
module fb_clear_sweeper import fb_pkg::*; #(
    parameter int unsigned ScreenW = fb_pkg::SCREEN_W,
    parameter int unsigned ScreenH = fb_pkg::SCREEN_H
) (
    input  logic   clk,
    input  logic   restart,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    localparam coord_t MaxX = coord_t'(ScreenW - 1);
    localparam coord_t MaxY = coord_t'(ScreenH - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // A restart takes effect combinationally so the restarted sweep's first
    // pixel can be issued in the same cycle the restart is seen.
    assign x    = restart ? '0 : x_q;
    assign y    = restart ? '0 : y_q;
    assign last = (x == MaxX) && (y == MaxY);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x == MaxX) begin
                x_d = '0;
                y_d = (y == MaxY) ? '0 : y + 1'b1;
            end else begin
                x_d = x + 1'b1;
                y_d = y;
            end
        end else if (restart) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Owner of the VGA framebuffer's single write port. Runs a full-screen clear
// sweep after reset and on clear_req, otherwise arbitrates two pixel
// requesters one pixel per cycle and bounds-checks every write address.
//   CLOCK_50   : system clock
//   reset      : synchronous, active-high
//   clear_req  : level; start/restart a full-screen clear
//   req_bus    : requester bus (req/x/y/color in, gnt out), slave side
//   fb_x/fb_y  : framebuffer write address (registered)
//   fb_color   : framebuffer write colour (registered)
//   fb_write   : framebuffer write enable (registered)
//   clear_busy : sweep pixel on fb_* this cycle
//   oob_err    : sticky; an out-of-range request was dropped
// Build option: define FB_SCHED_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise requester 0 has fixed priority.
module fb_write_scheduler import fb_pkg::*; #(
    parameter int unsigned ScreenW = fb_pkg::SCREEN_W,
    parameter int unsigned ScreenH = fb_pkg::SCREEN_H
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       clear_req,
    fb_write_scheduler_if.slave        req_bus,
    output coord_t                     fb_x,
    output coord_t                     fb_y,
    output logic                       fb_color,
    output logic                       fb_write,
    output logic                       clear_busy,
    output logic                       oob_err
);

    localparam coord_t MaxX = coord_t'(ScreenW - 1);
    localparam coord_t MaxY = coord_t'(ScreenH - 1);

    sched_state_t state_q, state_d;
    pixel_t       fb_q, fb_d;
    logic         fb_write_q, fb_write_d;
    logic         busy_q, busy_d;
    logic         oob_q, oob_d;

    coord_t       sweep_x, sweep_y;
    logic         sweep_last, sweep_adv, sweep_restart;

    logic         any_req;
    logic         winner;
    logic [1:0]   gnt;
    pixel_t       sel;
    logic         sel_ok;

    // ---------------------------------------------------------------- sweep
    assign sweep_restart = reset | clear_req;
    // Gated by reset so the counter sits at (0,0) when reset releases.
    assign sweep_adv     = (state_q == S_CLEAR) && !reset;

    fb_clear_sweeper #(
        .ScreenW (ScreenW),
        .ScreenH (ScreenH)
    ) u_sweeper (
        .clk     (CLOCK_50),
        .restart (sweep_restart),
        .advance (sweep_adv),
        .x       (sweep_x),
        .y       (sweep_y),
        .last    (sweep_last)
    );

    // ---------------------------------------------------------- arbitration
    assign any_req = |req_bus.req;

`ifdef FB_SCHED_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the requester not granted most recently wins.
    assign winner = (&req_bus.req) ? ~last_q : ~req_bus.req[0];
    assign last_d = (|gnt) ? winner : last_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = ~req_bus.req[0];
`endif

    assign sel = '{x: req_bus.x[winner], y: req_bus.y[winner], color: req_bus.color[winner]};
    assign sel_ok = (sel.x <= MaxX) && (sel.y <= MaxY);

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        fb_d       = fb_q;
        fb_write_d = 1'b0;
        busy_d     = 1'b0;
        oob_d      = oob_q;
        gnt        = 2'b00;

        unique case (state_q)
            S_CLEAR: begin
                fb_d       = '{x: sweep_x, y: sweep_y, color: 1'b0};
                fb_write_d = 1'b1;
                busy_d     = 1'b1;
                if (sweep_last && !clear_req) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                // clear_req beats any pending request; nothing is granted.
                if (clear_req) begin
                    state_d = S_CLEAR;
                end else if (any_req && !reset) begin
                    gnt[winner] = 1'b1;
                    if (sel_ok) begin
                        fb_d       = sel;
                        fb_write_d = 1'b1;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            fb_q       <= '0;
            fb_write_q <= 1'b0;
            busy_q     <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_q       <= fb_d;
            fb_write_q <= fb_write_d;
            busy_q     <= busy_d;
            oob_q      <= oob_d;
        end
    end

    assign req_bus.gnt = gnt;
    assign fb_x        = fb_q.x;
    assign fb_y        = fb_q.y;
    assign fb_color    = fb_q.color;
    assign fb_write    = fb_write_q;
    assign clear_busy  = busy_q;
    assign oob_err     = oob_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler on a reduced 64x48 raster so a
// full sweep stays short. Expected framebuffer writes go into a scoreboard
// queue as stimulus is driven; a monitor pops and compares on every write.
module tb_fb_write_scheduler;
    import fb_pkg::*;

    localparam int unsigned W = 64;
    localparam int unsigned H = 48;
    localparam int unsigned SWEEP = W * H;

    logic   CLOCK_50 = 1'b0;
    logic   reset    = 1'b1;
    logic   clear_req = 1'b0;
    coord_t fb_x, fb_y;
    logic   fb_color, fb_write, clear_busy, oob_err;

    fb_write_scheduler_if bus ();

    fb_write_scheduler #(
        .ScreenW (W),
        .ScreenH (H)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .clear_req  (clear_req),
        .req_bus    (bus),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_color   (fb_color),
        .fb_write   (fb_write),
        .clear_busy (clear_busy),
        .oob_err    (oob_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int     n_chk  = 0;
    int     n_pass = 0;
    pixel_t exp_q[$];
    logic   mon_en  = 1'b0;
    logic   rr_last = 1'b1;   // model of the round-robin pointer

    // Scoreboard monitor: every framebuffer write must match the next expectation.
    always @(negedge CLOCK_50) begin
        if (mon_en && fb_write) begin
            pixel_t got;
            pixel_t e;
            got = '{x: fb_x, y: fb_y, color: fb_color};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected got (%0d,%0d,%0d) required no write",
                         fb_x, fb_y, fb_color);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    $display("FAIL write_data got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                             got.x, got.y, got.color, e.x, e.y, e.color);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_sweep();
        for (int yy = 0; yy < int'(H); yy++) begin
            for (int xx = 0; xx < int'(W); xx++) begin
                exp_q.push_back('{x: coord_t'(xx), y: coord_t'(yy), color: 1'b0});
            end
        end
    endtask

    task automatic drive_req(input logic [1:0] r, input int x0, input int y0, input logic c0,
                             input int x1, input int y1, input logic c1);
        bus.req      = r;
        bus.x[0]     = coord_t'(x0);
        bus.y[0]     = coord_t'(y0);
        bus.color[0] = c0;
        bus.x[1]     = coord_t'(x1);
        bus.y[1]     = coord_t'(y1);
        bus.color[1] = c1;
    endtask

    // 1: reset state, then one full sweep in raster order.
    task automatic test_reset();
        int busy_cnt;
        drive_req(2'b00, 0, 0, 1'b0, 0, 0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        n_chk++;
        if ({fb_write, fb_color, clear_busy, oob_err, bus.gnt} !== 6'b0 ||
            fb_x !== '0 || fb_y !== '0) begin
            $display("FAIL reset_outputs got w=%b c=%b busy=%b oob=%b gnt=%b x=%0d y=%0d required all 0",
                     fb_write, fb_color, clear_busy, oob_err, bus.gnt, fb_x, fb_y);
        end else n_pass++;
        push_sweep();
        mon_en = 1'b1;
        reset  = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < int'(SWEEP) + 20; i++) begin
            @(negedge CLOCK_50);
            if (!clear_busy) break;
            busy_cnt++;
        end
        n_chk++;
        if (busy_cnt !== int'(SWEEP)) begin
            $display("FAIL sweep_busy_cycles got %0d required %0d", busy_cnt, SWEEP);
        end else n_pass++;
        n_chk++;
        if (exp_q.size() !== 0) begin
            $display("FAIL sweep_all_written got %0d pending required 0", exp_q.size());
        end else n_pass++;
    endtask

    // 2: single request, latency 1, then idle holds the last address.
    task automatic test_single();
        drive_req(2'b01, 10, 20, 1'b1, 0, 0, 1'b0);
        #1;
        n_chk++;
        if (bus.gnt !== 2'b01) $display("FAIL single_gnt got %b required 01", bus.gnt);
        else n_pass++;
        exp_q.push_back('{x: 11'd10, y: 11'd20, color: 1'b1});
        rr_last = 1'b0;
        @(negedge CLOCK_50);
        bus.req = 2'b00;
        #1;
        n_chk++;
        if (bus.gnt !== 2'b00) $display("FAIL idle_gnt got %b required 00", bus.gnt);
        else n_pass++;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_write !== 1'b0 || fb_x !== 11'd10 || fb_y !== 11'd20 || fb_color !== 1'b1) begin
            $display("FAIL idle_hold got w=%b (%0d,%0d,%0d) required w=0 (10,20,1)",
                     fb_write, fb_x, fb_y, fb_color);
        end else n_pass++;
    endtask

    // 3: both requesting continuously.
    task automatic test_tie();
        int         w;
        logic [1:0] exp_g;
        drive_req(2'b11, 5, 5, 1'b0, 6, 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
`ifdef FB_SCHED_ROUND_ROBIN_EN
            w = rr_last ? 0 : 1;
`else
            w = 0;
`endif
            exp_g = 2'b01 << w;
            n_chk++;
            if (bus.gnt !== exp_g) $display("FAIL tie_gnt[%0d] got %b required %b", i, bus.gnt, exp_g);
            else n_pass++;
            if (w == 0) exp_q.push_back('{x: 11'd5, y: 11'd5, color: 1'b0});
            else        exp_q.push_back('{x: 11'd6, y: 11'd6, color: 1'b1});
            rr_last = (w != 0);
            @(negedge CLOCK_50);
        end
        bus.req = 2'b00;
        @(negedge CLOCK_50);
    endtask

    // 4: out-of-range requests are consumed but never written; oob_err is sticky.
    task automatic test_oob();
        drive_req(2'b10, 0, 0, 1'b0, int'(W), 0, 1'b1);
        #1;
        n_chk++;
        if (bus.gnt !== 2'b10) $display("FAIL oob_x_gnt got %b required 10", bus.gnt);
        else n_pass++;
        rr_last = 1'b1;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_write !== 1'b0 || oob_err !== 1'b1) begin
            $display("FAIL oob_x_drop got w=%b oob=%b required w=0 oob=1", fb_write, oob_err);
        end else n_pass++;
        drive_req(2'b01, 0, int'(H), 1'b1, 0, 0, 1'b0);
        #1;
        n_chk++;
        if (bus.gnt !== 2'b01) $display("FAIL oob_y_gnt got %b required 01", bus.gnt);
        else n_pass++;
        rr_last = 1'b0;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_write !== 1'b0) $display("FAIL oob_y_drop got w=%b required 0", fb_write);
        else n_pass++;
        drive_req(2'b10, 0, 0, 1'b0, int'(W) - 1, int'(H) - 1, 1'b1);
        #1;
        n_chk++;
        if (bus.gnt !== 2'b10) $display("FAIL corner_gnt got %b required 10", bus.gnt);
        else n_pass++;
        exp_q.push_back('{x: coord_t'(W - 1), y: coord_t'(H - 1), color: 1'b1});
        rr_last = 1'b1;
        @(negedge CLOCK_50);
        bus.req = 2'b00;
        @(negedge CLOCK_50);
        n_chk++;
        if (oob_err !== 1'b1) $display("FAIL oob_sticky got %b required 1", oob_err);
        else n_pass++;
    endtask

    // 5: clear wins over a held request; the request waits out the sweep.
    task automatic test_clear_vs_req();
        int wait_cnt;
        drive_req(2'b01, 30, 40, 1'b1, 0, 0, 1'b0);
        clear_req = 1'b1;
        #1;
        n_chk++;
        if (bus.gnt !== 2'b00) $display("FAIL clear_wins_gnt got %b required 00", bus.gnt);
        else n_pass++;
        push_sweep();
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        wait_cnt  = 0;
        for (int i = 0; i < int'(SWEEP) + 20; i++) begin
            #1;
            if (bus.gnt !== 2'b00) break;
            wait_cnt++;
            @(negedge CLOCK_50);
        end
        n_chk++;
        if (wait_cnt !== int'(SWEEP)) begin
            $display("FAIL clear_no_grant_cycles got %0d required %0d", wait_cnt, SWEEP);
        end else n_pass++;
        n_chk++;
        if (bus.gnt !== 2'b01) $display("FAIL post_clear_gnt got %b required 01", bus.gnt);
        else n_pass++;
        exp_q.push_back('{x: 11'd30, y: 11'd40, color: 1'b1});
        rr_last = 1'b0;
        @(negedge CLOCK_50);
        bus.req = 2'b00;
        @(negedge CLOCK_50);
        n_chk++;
        if (exp_q.size() !== 0) $display("FAIL clear_drain got %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    // 6: restart mid-sweep by clear_req, then by reset.
    task automatic test_restart();
        logic found;
        mon_en    = 1'b0;
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < int'(SWEEP); i++) begin
            @(negedge CLOCK_50);
            if (fb_write && fb_x == 11'd19 && fb_y == 11'd3) begin
                found = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!found) $display("FAIL sweep_reach got no (19,3) required (19,3)");
        else n_pass++;
        clear_req = 1'b1;   // sweep counter now at (20,3)
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        n_chk++;
        if (fb_write !== 1'b1 || fb_x !== 11'd0 || fb_y !== 11'd0 || clear_busy !== 1'b1) begin
            $display("FAIL restart_origin got w=%b (%0d,%0d) busy=%b required w=1 (0,0) busy=1",
                     fb_write, fb_x, fb_y, clear_busy);
        end else n_pass++;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_x !== 11'd1 || fb_y !== 11'd0) begin
            $display("FAIL restart_step got (%0d,%0d) required (1,0)", fb_x, fb_y);
        end else n_pass++;
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        #1;
        n_chk++;
        if ({fb_write, fb_color, clear_busy, oob_err, bus.gnt} !== 6'b0 ||
            fb_x !== '0 || fb_y !== '0) begin
            $display("FAIL midreset_outputs got w=%b c=%b busy=%b oob=%b gnt=%b x=%0d y=%0d required all 0",
                     fb_write, fb_color, clear_busy, oob_err, bus.gnt, fb_x, fb_y);
        end else n_pass++;
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_write !== 1'b1 || fb_x !== 11'd0 || fb_y !== 11'd0 || fb_color !== 1'b0) begin
            $display("FAIL reset_restart got w=%b (%0d,%0d,%0d) required w=1 (0,0,0)",
                     fb_write, fb_x, fb_y, fb_color);
        end else n_pass++;
        @(negedge CLOCK_50);
        n_chk++;
        if (fb_x !== 11'd1 || fb_y !== 11'd0) begin
            $display("FAIL reset_restart_step got (%0d,%0d) required (1,0)", fb_x, fb_y);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_oob();
        test_clear_vs_req();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
